v_widen: RTL

Vector widening unit: the inverse of the ALU's narrowing stage. It accepts one full-width source beat of SEW-sized elements and emits two result beats of 2·SEW elements. Beat 0 carries the lower half of the source elements; beat 1 carries the upper half. Each element is sign- or zero-extended. The unit sits between the VRF read path and widening ALU ops (vwadd/vwmul operand prep, vsext/vzext) and uses valid/ready on both sides.

---
 rtl/v_widen.sv | 112 +++++++++++
 1 files changed

// File: rtl/v_widen.sv
// v_widen: widens one SEW source beat into two 2*SEW result beats (lower half, then upper half).
// Define V_WIDEN_SIGNED_EN to honour in_signed; otherwise every element is zero-extended.
module v_widen #(
    parameter int REQ_DATA_WIDTH    = 64,
    parameter int RESP_DATA_WIDTH   = 64,
    parameter int SEW_WIDTH         = 2,
    parameter int REQ_BYTE_EN_WIDTH = 8,
    parameter bit ENABLE_64_BIT     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_DATA_WIDTH-1:0]    in_vec,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEW_WIDTH-1:0]         in_sew,
    input  logic                         in_signed,
    input  logic [REQ_BYTE_EN_WIDTH-1:0] in_be,
    output logic [RESP_DATA_WIDTH-1:0]   out_vec,
    output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
    output logic [SEW_WIDTH-1:0]         out_sew,
    output logic                         out_turn,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int DW = REQ_DATA_WIDTH;
    localparam int HW = DW / 2;
    localparam int BW = REQ_BYTE_EN_WIDTH;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
    state_t state, state_nx;

    logic [DW-1:0]        h_vec;
    logic [SEW_WIDTH-1:0] h_sew;
    logic [BW-1:0]        h_be;
    logic                 sx, accept, fire, legal;
    logic [HW-1:0]        half;
    logic [BW/2-1:0]      half_be;
    logic [BW-1:0]        be_w;
    logic [DW-1:0]        w8, w16, w32, wide;

    assign out_valid = state != IDLE;
    assign out_turn  = state == BEAT1;
    assign in_ready  = (state == IDLE) | ((state == BEAT1) & out_ready);
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? BEAT0 : IDLE;
            BEAT0:   state_nx = fire ? BEAT1 : BEAT0;
            BEAT1:   state_nx = fire ? (accept ? BEAT0 : IDLE) : BEAT1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            h_vec <= '0;
            h_sew <= '0;
            h_be  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                h_vec <= in_vec;
                h_sew <= in_sew;
                h_be  <= in_be;
            end
        end
    end

`ifdef V_WIDEN_SIGNED_EN
    logic h_signed;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            h_signed <= 1'b0;
        else if (accept)
            h_signed <= in_signed;
    end
    assign sx = h_signed;
`else
    logic unused_signed;
    assign unused_signed = in_signed;
    assign sx = 1'b0;
`endif

    // 64-bit results only exist when the 32b source width is enabled
    assign legal = (h_sew < SEW_WIDTH'(2)) | ((h_sew == SEW_WIDTH'(2)) & ENABLE_64_BIT);

    always_comb begin
        half    = out_turn ? h_vec[DW-1:HW] : h_vec[HW-1:0];
        half_be = out_turn ? h_be[BW-1:BW/2] : h_be[BW/2-1:0];
        w8      = '0;
        w16     = '0;
        w32     = '0;
        be_w    = '0;
        for (int k = 0; k < DW / 16; k++)
            w8[k*16 +: 16] = {{8{sx & half[k*8+7]}}, half[k*8 +: 8]};
        for (int k = 0; k < DW / 32; k++)
            w16[k*32 +: 32] = {{16{sx & half[k*16+15]}}, half[k*16 +: 16]};
        for (int k = 0; k < DW / 64; k++)
            w32[k*64 +: 64] = {{32{sx & half[k*32+31]}}, half[k*32 +: 32]};
        for (int j = 0; j < BW; j++)
            be_w[j] = half_be[j/2];
        wide = (h_sew == SEW_WIDTH'(0)) ? w8 : (h_sew == SEW_WIDTH'(1)) ? w16 : w32;
    end

    assign out_vec = (out_valid & legal) ? wide : '0;
    assign out_be  = (out_valid & legal) ? be_w : '0;
    assign out_sew = out_valid ? h_sew + SEW_WIDTH'(1) : '0;
endmodule
